// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, frame geometry, baud divisors at 50 MHz.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    localparam int BAUD_DIV_9600   = 5208;
    localparam int BAUD_DIV_115200 = 434;
endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 serialiser: start pulse latches the byte, start bit on tx from the next cycle, done pulses after the stop bit.
// Latency: 10*BAUD_DIV cycles start-to-done; no backpressure, start is ignored while busy.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600
)(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic          tx_nxt, busy_nxt, done_nxt;
    logic          bit_end;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        tx_nxt      = tx;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        bit_end     = (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt   = data;
                    bit_idx_nxt = '0;
                    cnt_nxt     = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = shreg[0];
                    shreg_nxt = {1'b0, shreg[7:1]};
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shreg[0];
                        shreg_nxt   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX line among NREQ byte producers; ack and start bit one cycle after the grant edge.
// Latency: 10*BAUD_DIV+1 cycles per frame back-to-back; requests are simply held off while a frame is in flight.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BAUD_DIV = BAUD_DIV_9600,
    parameter int IDW      = 2
)(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NREQ-1:0]   iReq,
    input  logic [NREQ*8-1:0] iData,
    output logic [NREQ-1:0]   oAck,
    output logic [NREQ-1:0]   oDone,
    output logic              oBusy,
    output logic [IDW-1:0]    oGrantId,
    output logic              oTxPin
);
    logic [IDW-1:0] rr_last;
    logic [IDW-1:0] win;
    logic [IDW-1:0] arb_idx;
    logic           found;
    logic           grant;
    logic [7:0]     win_byte;
    logic           frame_done;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        win     = rr_last;
        arb_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_idx = IDW'((int'(rr_last) + i) % NREQ);
            if (!found && iReq[arb_idx]) begin
                found = 1'b1;
                win   = arb_idx;
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i))
                win_byte = iData[i*8 +: 8];
        end
    end

    assign grant = found & ~oBusy;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            oAck     <= '0;
            oGrantId <= '0;
            rr_last  <= IDW'(NREQ - 1);
        end else begin
            oAck <= grant ? (NREQ'(1) << win) : '0;
            if (grant) begin
                oGrantId <= win;
                rr_last  <= win;
            end
        end
    end

    assign oDone = frame_done ? (NREQ'(1) << oGrantId) : '0;

    uart_tx_frame #(
        .BAUD_DIV (BAUD_DIV)
    ) u_frame (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .start (grant),
        .data  (win_byte),
        .tx    (oTxPin),
        .busy  (oBusy),
        .done  (frame_done)
    );
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: instance a runs at BAUD_DIV=4, instance b at BAUD_DIV=2; outputs sampled on the falling edge.
module tb_uart_tx_sched;
    logic        CLK;
    logic        RSTn;
    logic [3:0]  req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  ack_a, ack_b, done_a, done_b;
    logic        busy_a, busy_b, tx_a, tx_b;
    logic [1:0]  gid_a, gid_b;

    int vectors;
    int miscompares;

    uart_tx_sched #(.NREQ(4), .BAUD_DIV(4), .IDW(2)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .iReq(req_a), .iData(data_a), .oAck(ack_a),
        .oDone(done_a), .oBusy(busy_a), .oGrantId(gid_a), .oTxPin(tx_a)
    );

    uart_tx_sched #(.NREQ(4), .BAUD_DIV(2), .IDW(2)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .iReq(req_b), .iData(data_b), .oAck(ack_b),
        .oDone(done_b), .oBusy(busy_b), .oGrantId(gid_b), .oTxPin(tx_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of stimulus, required finish before 400000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Call on the falling edge of the ack cycle; returns on the done cycle
    // (or right after an asynchronous reset when abort_j >= 0).
    task automatic run_frame(input bit sel, input logic [7:0] b, input int id,
                             input bit drop, input logic [3:0] mid, input int abort_j);
        int bd;
        bd = sel ? 2 : 4;
        for (int j = 0; j < 10*bd; j++) begin
            if (j == abort_j) begin
                RSTn = 1'b0;
                #1;
                check("abort_tx",   32'(sel ? tx_b : tx_a), 32'd1);
                check("abort_busy", 32'(sel ? busy_b : busy_a), 32'd0);
                check("abort_done", 32'(sel ? done_b : done_a), 32'd0);
                return;
            end
            check("tx",   32'(sel ? tx_b : tx_a), 32'(frame_bit(b, j / bd)));
            check("busy", 32'(sel ? busy_b : busy_a), 32'd1);
            check("done_low", 32'(sel ? done_b : done_a), 32'd0);
            if (j == 0) begin
                check("ack",   32'(sel ? ack_b : ack_a), 32'(4'(1) << id));
                check("grant", 32'(sel ? gid_b : gid_a), 32'(id));
                if (drop) begin
                    if (sel) req_b[id] = 1'b0;
                    else     req_a[id] = 1'b0;
                end
            end else begin
                check("ack_low", 32'(sel ? ack_b : ack_a), 32'd0);
            end
            if (j == 3*bd) req_a = req_a | mid;
            if (j == 9*bd - 1) req_a = req_a & ~mid;
            @(negedge CLK);
        end
        check("done",      32'(sel ? done_b : done_a), 32'(4'(1) << id));
        check("done_busy", 32'(sel ? busy_b : busy_a), 32'd0);
        check("done_tx",   32'(sel ? tx_b : tx_a), 32'd1);
        check("done_ack",  32'(sel ? ack_b : ack_a), 32'd0);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ack"},  32'(ack_a),  32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_tx"},   32'(tx_a),   32'd1);
        check({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RSTn   = 1'b0;
        req_a  = '0;
        req_b  = '0;
        data_a = '0;
        data_b = '0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_tx",   32'(tx_a),   32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ack",  32'(ack_a),  32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_gid",  32'(gid_a),  32'd0);
        check("rst_tx_b", 32'(tx_b),   32'd1);
        RSTn = 1'b1;
        @(negedge CLK);
        check_idle_a("idle0");

        // Single 0x55 frame from requester 0
        req_a       = 4'b0001;
        data_a[7:0] = 8'h55;
        @(negedge CLK);
        run_frame(1'b0, 8'h55, 0, 1'b1, 4'b0000, -1);
        @(negedge CLK);
        check_idle_a("idle1");

        // All four requesting from reset: grants 0,1,2,3 at 41-cycle period
        RSTn   = 1'b0;
        req_a  = 4'b1111;
        data_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(negedge CLK);
        check("rst_nogrant", 32'(ack_a), 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b0, 8'hA0 + 8'(i), i, 1'b1, 4'b0000, -1);
            @(negedge CLK);
        end
        check_idle_a("idle2");

        // Requesters 0 and 2 held continuously: 0,2,0,2,0,2
        RSTn   = 1'b0;
        req_a  = 4'b0101;
        data_a = {8'h00, 8'hC3, 8'h00, 8'h3C};
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        for (int f = 0; f < 6; f++) begin
            run_frame(1'b0, (f % 2) ? 8'hC3 : 8'h3C, (f % 2) ? 2 : 0, 1'b0, 4'b0000, -1);
            if (f == 5) req_a = '0;
            @(negedge CLK);
        end
        check_idle_a("idle3");

        // Requester 1 raised during DATA and withdrawn before STOP ends
        req_a       = 4'b0001;
        data_a[7:0] = 8'h5A;
        @(negedge CLK);
        run_frame(1'b0, 8'h5A, 0, 1'b1, 4'b0010, -1);
        @(negedge CLK);
        check_idle_a("idle4a");
        @(negedge CLK);
        check_idle_a("idle4b");

        // Reset mid-DATA, then requester 3 pending after release
        req_a        = 4'b0010;
        data_a[15:8] = 8'h81;
        @(negedge CLK);
        run_frame(1'b0, 8'h81, 1, 1'b1, 4'b0000, 14);
        req_a         = 4'b1000;
        data_a[31:24] = 8'h96;
        @(negedge CLK);
        check_idle_a("in_rst");
        RSTn = 1'b1;
        @(negedge CLK);
        run_frame(1'b0, 8'h96, 3, 1'b1, 4'b0000, -1);
        @(negedge CLK);
        check_idle_a("idle5");

        // BAUD_DIV=2: 0xFF then 0x00, 20-cycle frames, 21-cycle period
        req_b       = 4'b0001;
        data_b[7:0] = 8'hFF;
        @(negedge CLK);
        run_frame(1'b1, 8'hFF, 0, 1'b1, 4'b0000, -1);
        req_b       = 4'b0001;
        data_b[7:0] = 8'h00;
        @(negedge CLK);
        run_frame(1'b1, 8'h00, 0, 1'b1, 4'b0000, -1);
        @(negedge CLK);
        check("idle6_ack",  32'(ack_b),  32'd0);
        check("idle6_busy", 32'(busy_b), 32'd0);
        check("idle6_tx",   32'(tx_b),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit line among NREQ byte producers. Each producer presents a byte with a level request. The scheduler grants one producer, latches its byte and serialises it as an 8N1 frame at the configured baud rate. It then re-arbitrates. It sits between on-chip message sources (status, debug, command replies) and the board TX pin.

Parameters:
NREQ, 4, number of requesters (2..8)
BAUD_DIV, 5208, clock cycles per bit period (50 MHz / 9600); legal range >= 2
IDW, 2, width of grant index, equal to clog2(NREQ)

Ports:
CLK  in  1  system clock, rising edge
RSTn  in  1  asynchronous active-low reset
iReq  in  NREQ  per-requester level request; hold with iData stable until oAck
iData  in  NREQ*8  byte of requester i on bits [8i+7:8i]
oAck  out  NREQ  one-cycle pulse: byte of requester i latched, may be changed
oDone  out  NREQ  one-cycle pulse: stop bit of requester i's frame finished
oBusy  out  1  high while a frame is in progress (START..STOP)
oGrantId  out  IDW  index of the requester currently or last granted
oTxPin  out  1  serial line, idle high

Behaviour:
- Reset (async, RSTn low): oTxPin=1, oAck=0, oDone=0, oBusy=0, oGrantId=0, state IDLE, baud counter 0, round-robin pointer set so requester 0 has highest priority. Reset mid-frame aborts the frame, and the line goes high immediately. No oDone is issued.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: on each edge, if any iReq bit is high, grant the first set bit searching from (last granted + 1) mod NREQ upward with wrap. On that edge:
  - latch the byte
  - oGrantId <= winner
  - oAck[winner] pulses for exactly the next cycle
  - oBusy <= 1
  - state <= START
  - oTxPin <= 0
  - baud counter <= 0
  If no request is pending, stay in IDLE with oTxPin=1.
- Latency: iReq sampled high at edge k in IDLE -> oAck and the start bit both visible from cycle k+1.
- Bit timing: every bit (start, 8 data, stop) is held for exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1, and advance happens on the cycle where the counter equals BAUD_DIV-1.
- DATA: LSB first, bit index 0..7. After bit 7 completes, go to STOP with oTxPin=1.
- STOP: after BAUD_DIV cycles, the following all occur on one edge:
  - oDone[oGrantId] pulses for one cycle
  - oBusy <= 0
  - state <= IDLE
- Frame occupancy is 10*BAUD_DIV cycles. At least one IDLE arbitration cycle separates frames, so the back-to-back period is 10*BAUD_DIV+1 cycles.
- Requests arriving while busy are not acknowledged; they are considered at the next IDLE. Deasserting iReq before oAck withdraws the request with no side effect. iReq held after oAck is treated as a new request.
- Round-robin pointer updates only on grant. It is unaffected by withdrawn requests.
- oAck and oDone are never both asserted for the same requester in the same cycle. At most one bit of each vector is high at a time.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - UART_DATA_BITS=8, UART_FRAME_BITS=10
  - default BAUD_DIV constants (9600/115200 at 50 MHz)
- Sub-module uart_tx_frame: baud counter, shift register and bit index.
  - Inputs: start pulse and byte.
  - Outputs: tx pin, busy, and a done pulse.
- uart_tx_sched keeps the round-robin arbiter, grant and ack/done routing.

Test Plan:
- BAUD_DIV=4, iReq=4'b0001, iData[7:0]=8'h55 -> oAck[0] one cycle after first sample. oTxPin then runs 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. oDone[0] pulses 40 cycles after oAck.
- All four iReq high simultaneously from reset, bytes 8'hA0..8'hA3 -> grants in order 0,1,2,3. oTxPin frames appear back-to-back at 41-cycle period.
- iReq[0] and iReq[2] held continuously for 6 frames -> oGrantId alternates 0,2,0,2,0,2. Requester 0 is never granted twice in a row.
- iReq[1] raised during frame 0's DATA state and dropped before STOP ends -> no oAck[1]; line idles high after frame 0.
- RSTn pulled low mid-DATA of a frame -> oTxPin=1 and oBusy=0 in the same cycle, no oDone. After release with iReq[3] pending, requester 3 is granted and the frame is complete and correct.
- BAUD_DIV=2, 8'hFF and 8'h00 frames -> start low and stop high held exactly 2 cycles each. Total frame is 20 cycles.
